vga_interface: RTL and testbench
================================

Name: vga_interface

Overview:
Display back-end stage, directly downstream of the snake/colour generation logic. Generates 640x480@60 Hz VGA timing from the 100 MHz system clock via a pixel-enable divider. Publishes the current pixel address (ADDRH, ADDRY) to the colour generator and registers the returned 12-bit colour onto the VGA pins. The returned colour is blanked outside the visible area, and HS/VS are kept aligned with the colour.

Parameters:
CLK_DIV, 4, system clocks per pixel; legal range 2..16.
H_VISIBLE, 640, visible pixels per line.
H_FRONT, 16, horizontal front porch in pixels.
H_SYNC, 96, horizontal sync width in pixels.
H_BACK, 48, horizontal back porch in pixels.
V_VISIBLE, 480, visible lines per frame.
V_FRONT, 10, vertical front porch in lines.
V_SYNC, 2, vertical sync width in lines.
V_BACK, 33, vertical back porch in lines.

Ports:
CLK  in  1  system clock, 100 MHz.
RESET  in  1  asynchronous, active-low reset; 0 = reset.
COLOUR_IN  in  12  colour for the current ADDRH/ADDRY, from the colour generator; must settle within CLK_DIV-1 clocks.
ADDRH  out  10  current horizontal count, 0..H_TOTAL-1.
ADDRY  out  10  current vertical count, 0..V_TOTAL-1.
COLOUR_OUT  out  12  registered colour to the VGA DAC.
HS  out  1  horizontal sync, active low.
VS  out  1  vertical sync, active low.
FRAME_TICK  out  1  one-CLK pulse at end of frame.

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Reset (RESET=0, asynchronous): divider 0, ADDRH 0, ADDRY 0, COLOUR_OUT 0, HS 1, VS 1, FRAME_TICK 0. Takes effect immediately, including mid-line or mid-frame.
- Release: the first pixel enable occurs CLK_DIV clocks after the first CLK edge with RESET=1.
- Divider:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - Internal PIX_EN = (divider == CLK_DIV-1).
  - All state below updates only on CLK edges where PIX_EN=1, except FRAME_TICK clear.
- Counters (on PIX_EN):
  - ADDRH increments; it wraps from H_TOTAL-1 to 0.
  - On that wrap, ADDRY increments; ADDRY wraps from V_TOTAL-1 to 0.
  - ADDRH/ADDRY are registered outputs, stable for CLK_DIV clocks.
- Visible: VIS = (ADDRH < H_VISIBLE) && (ADDRY < V_VISIBLE), evaluated on the current, pre-increment counts.
- Output stage (on PIX_EN, same edge as the counter advance):
  - COLOUR_OUT <= VIS ? COLOUR_IN : 12'h000.
  - HS <= !(ADDRH in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for counts 656..751.
  - VS <= !(ADDRY in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. low for lines 490..491.
  - Colour, HS and VS therefore lag the published address by exactly one pixel period and remain mutually aligned.
- COLOUR_IN sampling: sampled only on PIX_EN edges; values between edges are ignored. Upstream registers its colour one CLK after the address changes, which is legal for CLK_DIV >= 2.
- FRAME_TICK:
  - Set to 1 on the PIX_EN edge where ADDRH == H_TOTAL-1 and ADDRY == V_TOTAL-1.
  - Cleared on the next CLK edge; width is exactly 1 CLK.
  - Period: H_TOTAL*V_TOTAL*CLK_DIV clocks, i.e. 1,680,000.
- No other inputs; counters never stall.

Test Plan:
1. Reset then release with COLOUR_IN=12'hFFF → during reset COLOUR_OUT=0, HS=VS=1, ADDRH=ADDRY=0; after release ADDRH steps to 1 after exactly 4 clocks and then every 4 clocks; COLOUR_OUT=12'hFFF from the first PIX_EN edge.
2. Run one line → HS low for exactly 96*4=384 clocks; HS falls 1 pixel (4 clocks) after ADDRH changes from 655 to 656; ADDRY increments when ADDRH wraps 799→0.
3. COLOUR_IN=12'h0F0 held constant → COLOUR_OUT=12'h0F0 for pixels 0..639 of lines 0..479; 0 for pixels 640..799 and lines 480..524; transition occurs one pixel after ADDRH reaches 640.
4. Run two full frames → VS low for 2*800*4=6400 clocks, starting one pixel after ADDRY=490/ADDRH=0 is presented; FRAME_TICK pulses are 1 clock wide and 1,680,000 clocks apart.
5. Assert RESET at ADDRH=300, ADDRY=200 with the divider at 2 → all outputs return to reset values asynchronously, without waiting for CLK; after release timing restarts from 0,0 as in scenario 1.
6. Colour changing every CLK (COLOUR_IN=incrementing counter) → COLOUR_OUT equals the COLOUR_IN value present on the PIX_EN edge only; intermediate values never appear.

Source files
------------

// File: rtl/vga_interface_if.sv
// Pixel-side bundle between the VGA timing stage and its neighbours.
//   COLOUR_IN   : 12-bit colour returned by the colour generator for ADDRH/ADDRY
//   ADDRH/ADDRY : current pixel address, 10 bits each
//   COLOUR_OUT  : registered colour to the DAC
//   HS/VS       : active-low syncs, aligned with COLOUR_OUT
//   FRAME_TICK  : one-clock end-of-frame pulse
// master = the timing stage, slave = the colour generator / pin side.
interface vga_interface_if;
  logic [11:0] COLOUR_IN;
  logic [9:0]  ADDRH;
  logic [9:0]  ADDRY;
  logic [11:0] COLOUR_OUT;
  logic        HS;
  logic        VS;
  logic        FRAME_TICK;

  modport master (
    input  COLOUR_IN,
    output ADDRH, ADDRY, COLOUR_OUT, HS, VS, FRAME_TICK
  );

  modport slave (
    output COLOUR_IN,
    input  ADDRH, ADDRY, COLOUR_OUT, HS, VS, FRAME_TICK
  );
endinterface

// File: rtl/vga_interface.sv
// VGA timing back-end: divides CLK into a pixel enable, runs the H/V pixel
// counters, publishes the address, and registers the returned colour (blanked
// outside the visible area) together with HS/VS so all three stay aligned.
// Ports:
//   CLK   : system clock
//   RESET : asynchronous active-low reset
//   vga   : vga_interface_if.master (COLOUR_IN in; ADDRH, ADDRY, COLOUR_OUT,
//           HS, VS, FRAME_TICK out)
module vga_interface #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic             CLK,
  input  logic             RESET,
  vga_interface_if.master  vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW      = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [11:0]   col_q, col_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          tick_q, tick_d;

  logic pix_en;
  logic h_wrap;
  logic v_wrap;
  logic vis;

  always_comb begin
    pix_en = (div_q == DIV_LAST);
    div_d  = pix_en ? '0 : div_q + DW'(1);

    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    vis    = (h_q < H_VIS) && (v_q < V_VIS);

    h_d    = h_q;
    v_d    = v_q;
    col_d  = col_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    // Default low so a set pulse clears on the very next CLK edge.
    tick_d = 1'b0;

    if (pix_en) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 10'd1;
      end
      // Decoded from the pre-increment counts, so these lag ADDRH/ADDRY by one pixel.
      col_d  = vis ? vga.COLOUR_IN : '0;
      hs_d   = !((h_q >= HS_START) && (h_q <= HS_END));
      vs_d   = !((v_q >= VS_START) && (v_q <= VS_END));
      tick_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      col_q  <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      col_q  <= col_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      tick_q <= tick_d;
    end
  end

  assign vga.ADDRH      = h_q;
  assign vga.ADDRY      = v_q;
  assign vga.COLOUR_OUT = col_q;
  assign vga.HS         = hs_q;
  assign vga.VS         = vs_q;
  assign vga.FRAME_TICK = tick_q;

endmodule

// File: tb/tb_vga_interface.sv
// Bench for vga_interface using a reduced screen geometry (30x15 totals,
// CLK_DIV=4) so several whole frames fit in a short run. The model derives
// every output from the number of CLK edges seen since reset release.
module tb_vga_interface;

  localparam int DIV = 4;
  localparam int HV = 16, HF = 4, HSW = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB;   // 30
  localparam int VT = VV + VF + VSW + VB;   // 15

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] colour_in = 12'hFFF;

  always #5 clk = ~clk;

  vga_interface_if vif();
  assign vif.COLOUR_IN = colour_in;

  vga_interface #(
    .CLK_DIV(DIV),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .CLK(clk),
    .RESET(rst_n),
    .vga(vif)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          t = 0;          // CLK edges since reset release
  logic [11:0] col_samp = '0;  // COLOUR_IN seen on the latest pixel-enable edge

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t = 0;
    else begin
      t = t + 1;
      if (t % DIV == 0) col_samp = colour_in;
    end
  end

  int          m_p, m_q, m_qh, m_qv;
  logic [11:0] e_col;
  logic        e_hs, e_vs, e_tick;

  always @(negedge clk) begin
    m_p = t / DIV;
    if (m_p == 0) begin
      e_col = '0; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      m_q  = m_p - 1;
      m_qh = m_q % HT;
      m_qv = (m_q / HT) % VT;
      e_col = (m_qh < HV && m_qv < VV) ? col_samp : 12'h000;
      e_hs  = !(m_qh >= HV + HF && m_qh < HV + HF + HSW);
      e_vs  = !(m_qv >= VV + VF && m_qv < VV + VF + VSW);
    end
    e_tick = (t > 0) && (t % DIV == 0) && (m_p % (HT * VT) == 0);
    chk("addrh",  32'(vif.ADDRH), 32'(m_p % HT));
    chk("addry",  32'(vif.ADDRY), 32'((m_p / HT) % VT));
    chk("colour", 32'(vif.COLOUR_OUT), 32'(e_col));
    chk("hs",     32'(vif.HS), 32'(e_hs));
    chk("vs",     32'(vif.VS), 32'(e_vs));
    chk("tick",   32'(vif.FRAME_TICK), 32'(e_tick));
  end

  // ---------------- pulse width / spacing measurement ----------------
  logic meas_en = 1'b0;
  int hs_run = 0, vs_run = 0, tk_run = 0, cyc = 0, last_tick = -1;
  int hs_runs[$], vs_runs[$], tk_w[$], tk_iv[$];

  always @(negedge clk) begin
    if (meas_en) begin
      cyc++;
      if (!vif.HS) hs_run++;
      else if (hs_run > 0) begin hs_runs.push_back(hs_run); hs_run = 0; end
      if (!vif.VS) vs_run++;
      else if (vs_run > 0) begin vs_runs.push_back(vs_run); vs_run = 0; end
      if (vif.FRAME_TICK) begin
        tk_run++;
        if (tk_run == 1) begin
          if (last_tick >= 0) tk_iv.push_back(cyc - last_tick);
          last_tick = cyc;
        end
      end else if (tk_run > 0) begin
        tk_w.push_back(tk_run);
        tk_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic found;

  initial begin
    // Reset with white on the input.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addrh", 32'(vif.ADDRH), 32'd0);
    chk("rst_addry", 32'(vif.ADDRY), 32'd0);
    chk("rst_colour", 32'(vif.COLOUR_OUT), 32'h000);
    chk("rst_hs", 32'(vif.HS), 32'd1);
    chk("rst_vs", 32'(vif.VS), 32'd1);

    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rel3_addrh", 32'(vif.ADDRH), 32'd0);
    chk("rel3_colour", 32'(vif.COLOUR_OUT), 32'h000);
    @(posedge clk); #1;
    chk("rel4_addrh", 32'(vif.ADDRH), 32'd1);
    chk("rel4_colour", 32'(vif.COLOUR_OUT), 32'hFFF);
    repeat (4) @(posedge clk);
    #1;
    chk("rel8_addrh", 32'(vif.ADDRH), 32'd2);

    // Two full frames with constant green.
    colour_in = 12'h0F0;
    meas_en = 1'b1;
    repeat (3700) @(posedge clk);
    #1 meas_en = 1'b0;
    chk("hs_runs_seen", 32'(hs_runs.size() >= 25), 32'd1);
    foreach (hs_runs[i]) chk("hs_low_width", 32'(hs_runs[i]), 32'd24);
    chk("vs_runs_seen", 32'(vs_runs.size()), 32'd2);
    foreach (vs_runs[i]) chk("vs_low_width", 32'(vs_runs[i]), 32'd240);
    chk("tick_count", 32'(tk_w.size()), 32'd2);
    foreach (tk_w[i]) chk("tick_width", 32'(tk_w[i]), 32'd1);
    chk("tick_iv_count", 32'(tk_iv.size()), 32'd1);
    foreach (tk_iv[i]) chk("tick_period", 32'(tk_iv[i]), 32'd1800);

    // Asynchronous reset at ADDRH=10, ADDRY=5, divider=2.
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (t % DIV == 2 && (t / DIV) % HT == 10 && ((t / DIV) / HT) % VT == 5) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_frame_reached", 32'(found), 32'd1);
    chk("pre_rst_addrh", 32'(vif.ADDRH), 32'd10);
    chk("pre_rst_addry", 32'(vif.ADDRY), 32'd5);
    chk("pre_rst_colour", 32'(vif.COLOUR_OUT), 32'h0F0);
    rst_n = 1'b0;
    #1;
    chk("arst_addrh", 32'(vif.ADDRH), 32'd0);
    chk("arst_addry", 32'(vif.ADDRY), 32'd0);
    chk("arst_colour", 32'(vif.COLOUR_OUT), 32'h000);
    chk("arst_hs", 32'(vif.HS), 32'd1);
    chk("arst_vs", 32'(vif.VS), 32'd1);
    chk("arst_tick", 32'(vif.FRAME_TICK), 32'd0);

    // Release with COLOUR_IN changing on every clock.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    colour_in = 12'h100;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      if (k == 3) chk("inc3_addrh", 32'(vif.ADDRH), 32'd0);
      if (k == 4) begin
        chk("inc4_addrh", 32'(vif.ADDRH), 32'd1);
        chk("inc4_colour", 32'(vif.COLOUR_OUT), 32'h103);
      end
      if (k == 8) begin
        chk("inc8_addrh", 32'(vif.ADDRH), 32'd2);
        chk("inc8_colour", 32'(vif.COLOUR_OUT), 32'h107);
      end
      @(negedge clk);
      colour_in = colour_in + 12'h001;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
